multicycle_controller: RTL and testbench

- Main control FSM for the multicycle variant of the RV32I core.
- Sequences the shared ALU, memory port, instruction register and PC/register-file write enables across multiple cycles per instruction.
- Drives imm_sel to configure the immediate generator format each cycle.
- Waits on a ready/request handshake for a variable-latency unified memory.

---
 rtl/multicycle_controller.sv | 204 ++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I core: steps the shared ALU, unified memory port,
// instruction register and PC/register-file write enables through each instruction.
module multicycle_controller #(
    parameter int Width      = 32,
    parameter int ImmSelBits = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_update,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_op,
    output logic [ImmSelBits-1:0] imm_sel,
    output logic                  illegal,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        LUI      = 4'd12,
        AUIPC    = 4'd13,
        TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    state_t cur;
    state_t nxt;
    logic   set_illegal;

    // funct7b5 feeds the separate ALU decoder; the width parameter is informational here
    logic unused_ok;
    assign unused_ok = funct7b5 ^ (Width == 0);

    assign state = cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= FETCH;
            illegal <= 1'b0;
        end else begin
            cur <= nxt;
            if (set_illegal) illegal <= 1'b1;
        end
    end

    // Moore decode of the current state; only ir_write/pc_update see mem_ready or the branch outcome
    always_comb begin
        nxt         = cur;
        set_illegal = 1'b0;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_update   = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_op      = 2'b00;
        imm_sel     = '0;
        case (cur)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write  = 1'b1;
                    pc_update = 1'b1;
                    nxt       = DECODE;
                end
            end
            DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_sel   = (opcode == OP_JAL) ? ImmSelBits'(3) : ImmSelBits'(2);
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = MEMADR;
                    OP_RTYPE:          nxt = EXECR;
                    OP_ITYPE:          nxt = EXECI;
                    OP_BRANCH:         nxt = BRANCH;
                    OP_JAL:            nxt = JAL;
                    OP_JALR:           nxt = JALR;
                    OP_LUI:            nxt = LUI;
                    OP_AUIPC:          nxt = AUIPC;
                    default:           nxt = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_sel   = (opcode == OP_STORE) ? ImmSelBits'(1) : ImmSelBits'(0);
                nxt       = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) nxt = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                nxt        = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) nxt = FETCH;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                nxt       = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                nxt       = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                nxt       = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                nxt       = FETCH;
                case (funct3)
                    3'b000:         pc_update = zero;
                    3'b001:         pc_update = ~zero;
                    3'b100:         pc_update = lt;
                    3'b101:         pc_update = ~lt;
                    3'b110:         pc_update = ltu;
                    3'b111:         pc_update = ~ltu;
                    3'b010, 3'b011: set_illegal = 1'b1;
                endcase
            end
            // JALR only forms the target in ALUOut, then reuses JAL for the PC/link update
            JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                nxt       = JAL;
            end
            JAL: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                nxt       = ALUWB;
            end
            LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                imm_sel   = ImmSelBits'(4);
                nxt       = ALUWB;
            end
            AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_sel   = ImmSelBits'(4);
                nxt       = ALUWB;
            end
            TRAP: begin
                set_illegal = 1'b1;
                nxt         = TRAP;
            end
            default: nxt = FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Table-driven bench for multicycle_controller: per-cycle vectors of inputs and expected state/outputs.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero, lt, ltu, mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_update, reg_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic [2:0] imm_sel;
    logic       illegal;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_controller #(.Width(32), .ImmSelBits(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_update(pc_update), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
        .imm_sel(imm_sel), .illegal(illegal), .state(state)
    );

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    typedef struct {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       z, l, lu, rdy;
        logic [3:0] st;
        logic       pc, ir, rw, ill;
    } vec_t;

    typedef struct packed {
        logic       req, wr, adr;
        logic [1:0] a, b, res, aop;
        logic [2:0] imm;
    } moore_t;

    vec_t vecs[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   vec_idx      = 0;

    // Expected state-only outputs for a given (expected) state and instruction opcode
    function automatic moore_t moore(input logic [3:0] st, input logic [6:0] op);
        moore_t m = '0;
        case (st)
            4'd0:  begin m.req = 1'b1; m.b = 2'b10; m.res = 2'b10; end
            4'd1:  begin m.a = 2'b01; m.b = 2'b01; m.imm = (op == OP_JAL) ? 3'd3 : 3'd2; end
            4'd2:  begin m.a = 2'b10; m.b = 2'b01; m.imm = (op == OP_ST) ? 3'd1 : 3'd0; end
            4'd3:  begin m.req = 1'b1; m.adr = 1'b1; end
            4'd4:  m.res = 2'b01;
            4'd5:  begin m.req = 1'b1; m.wr = 1'b1; m.adr = 1'b1; end
            4'd6:  begin m.a = 2'b10; m.aop = 2'b10; end
            4'd7:  begin m.a = 2'b10; m.b = 2'b01; m.aop = 2'b10; end
            4'd9:  begin m.a = 2'b10; m.aop = 2'b01; end
            4'd10: begin m.a = 2'b01; m.b = 2'b10; end
            4'd11: begin m.a = 2'b10; m.b = 2'b01; end
            4'd12: begin m.a = 2'b11; m.b = 2'b01; m.imm = 3'd4; end
            4'd13: begin m.a = 2'b01; m.b = 2'b01; m.imm = 3'd4; end
            default: ;
        endcase
        return m;
    endfunction

    function automatic logic taken(input logic [2:0] f3, input logic z, input logic l, input logic lu);
        case (f3)
            3'b000:  return z;
            3'b001:  return ~z;
            3'b100:  return l;
            3'b101:  return ~l;
            3'b110:  return lu;
            3'b111:  return ~lu;
            default: return 1'b0;
        endcase
    endfunction

    task automatic add(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                       input logic z, input logic l, input logic lu, input logic rdy,
                       input logic [3:0] st, input logic pc, input logic ir,
                       input logic rw, input logic ill);
        vec_t v;
        v.rst = rst; v.op = op; v.f3 = f3; v.z = z; v.l = l; v.lu = lu; v.rdy = rdy;
        v.st = st; v.pc = pc; v.ir = ir; v.rw = rw; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic row(input logic rst, input logic [6:0] op, input logic rdy, input logic [3:0] st,
                       input logic pc, input logic ir, input logic rw, input logic ill);
        add(rst, op, 3'b000, 1'b0, 1'b0, 1'b0, rdy, st, pc, ir, rw, ill);
    endtask

    task automatic compare(input string name, input logic [3:0] act, input logic [3:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at vector %0d: got %0d, expected %0d", name, vec_idx, act, exp);
        end
    endtask

    task automatic check_output(input vec_t v);
        moore_t m = moore(v.st, v.op);
        compare("state",      state,            v.st);
        compare("mem_req",    4'(mem_req),      4'(m.req));
        compare("mem_write",  4'(mem_write),    4'(m.wr));
        compare("adr_src",    4'(adr_src),      4'(m.adr));
        compare("ir_write",   4'(ir_write),     4'(v.ir));
        compare("pc_update",  4'(pc_update),    4'(v.pc));
        compare("reg_write",  4'(reg_write),    4'(v.rw));
        compare("alu_src_a",  4'(alu_src_a),    4'(m.a));
        compare("alu_src_b",  4'(alu_src_b),    4'(m.b));
        compare("result_src", 4'(result_src),   4'(m.res));
        compare("alu_op",     4'(alu_op),       4'(m.aop));
        compare("imm_sel",    4'(imm_sel),      4'(m.imm));
        compare("illegal",    4'(illegal),      4'(v.ill));
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later
    task automatic apply_stimulus(input vec_t v);
        reset     = v.rst;
        opcode    = v.op;
        funct3    = v.f3;
        zero      = v.z;
        lt        = v.l;
        ltu       = v.lu;
        mem_ready = v.rdy;
        #1;
        check_output(v);
        @(posedge clk);
        #1;
        vec_idx++;
    endtask

    initial begin
        reset = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;

        // R-type then I-type with memory always ready
        row(0, OP_R, 1, 0, 1, 1, 0, 0); row(0, OP_R, 1, 1, 0, 0, 0, 0);
        row(0, OP_R, 1, 6, 0, 0, 0, 0); row(0, OP_R, 1, 8, 0, 0, 1, 0);
        row(0, OP_I, 1, 0, 1, 1, 0, 0); row(0, OP_I, 1, 1, 0, 0, 0, 0);
        row(0, OP_I, 1, 7, 0, 0, 0, 0); row(0, OP_I, 1, 8, 0, 0, 1, 0);
        // Load: fetch waits twice, MEMREAD waits three cycles
        row(0, OP_LD, 0, 0, 0, 0, 0, 0); row(0, OP_LD, 0, 0, 0, 0, 0, 0);
        row(0, OP_LD, 1, 0, 1, 1, 0, 0); row(0, OP_LD, 1, 1, 0, 0, 0, 0);
        row(0, OP_LD, 1, 2, 0, 0, 0, 0);
        row(0, OP_LD, 0, 3, 0, 0, 0, 0); row(0, OP_LD, 0, 3, 0, 0, 0, 0);
        row(0, OP_LD, 0, 3, 0, 0, 0, 0); row(0, OP_LD, 1, 3, 0, 0, 0, 0);
        row(0, OP_LD, 0, 4, 0, 0, 1, 0);
        // Store with one wait cycle
        row(0, OP_ST, 1, 0, 1, 1, 0, 0); row(0, OP_ST, 1, 1, 0, 0, 0, 0);
        row(0, OP_ST, 1, 2, 0, 0, 0, 0); row(0, OP_ST, 0, 5, 0, 0, 0, 0);
        row(0, OP_ST, 1, 5, 0, 0, 0, 0);
        // LUI, AUIPC, JAL, JALR
        row(0, OP_LUI, 1, 0, 1, 1, 0, 0);   row(0, OP_LUI, 1, 1, 0, 0, 0, 0);
        row(0, OP_LUI, 1, 12, 0, 0, 0, 0);  row(0, OP_LUI, 1, 8, 0, 0, 1, 0);
        row(0, OP_AUIPC, 1, 0, 1, 1, 0, 0); row(0, OP_AUIPC, 1, 1, 0, 0, 0, 0);
        row(0, OP_AUIPC, 1, 13, 0, 0, 0, 0); row(0, OP_AUIPC, 1, 8, 0, 0, 1, 0);
        row(0, OP_JAL, 1, 0, 1, 1, 0, 0);   row(0, OP_JAL, 1, 1, 0, 0, 0, 0);
        row(0, OP_JAL, 1, 10, 1, 0, 0, 0);  row(0, OP_JAL, 1, 8, 0, 0, 1, 0);
        row(0, OP_JALR, 1, 0, 1, 1, 0, 0);  row(0, OP_JALR, 1, 1, 0, 0, 0, 0);
        row(0, OP_JALR, 1, 11, 0, 0, 0, 0); row(0, OP_JALR, 1, 10, 1, 0, 0, 0);
        row(0, OP_JALR, 1, 8, 0, 0, 1, 0);
        // Unsupported opcode traps; illegal is sticky until reset
        row(0, OP_BAD, 1, 0, 1, 1, 0, 0);   row(0, OP_BAD, 1, 1, 0, 0, 0, 0);
        row(0, OP_BAD, 1, 14, 0, 0, 0, 0);  row(0, OP_BAD, 1, 14, 0, 0, 0, 1);
        row(1, OP_BAD, 1, 14, 0, 0, 0, 1);
        // Reset in the middle of MEMREAD abandons the request
        row(0, OP_LD, 1, 0, 1, 1, 0, 0); row(0, OP_LD, 1, 1, 0, 0, 0, 0);
        row(0, OP_LD, 1, 2, 0, 0, 0, 0); row(1, OP_LD, 0, 3, 0, 0, 0, 0);
        row(0, OP_LD, 0, 0, 0, 0, 0, 0); row(0, OP_LD, 1, 0, 1, 1, 0, 0);
        row(0, OP_LD, 1, 1, 0, 0, 0, 0); row(0, OP_LD, 1, 2, 0, 0, 0, 0);
        row(0, OP_LD, 1, 3, 0, 0, 0, 0); row(0, OP_LD, 1, 4, 0, 0, 1, 0);
        // Every legal branch condition against every zero/lt/ltu combination
        for (int f = 0; f < 8; f++) begin
            if (f == 2 || f == 3) continue;
            for (int c = 0; c < 8; c++) begin
                add(0, OP_BR, 3'(f), c[0], c[1], c[2], 1, 4'd0, 1, 1, 0, 0);
                add(0, OP_BR, 3'(f), c[0], c[1], c[2], 1, 4'd1, 0, 0, 0, 0);
                add(0, OP_BR, 3'(f), c[0], c[1], c[2], 1, 4'd9,
                    taken(3'(f), c[0], c[1], c[2]), 0, 0, 0);
            end
        end
        // Reserved branch funct3 values never branch and raise illegal
        add(0, OP_BR, 3'b010, 1, 1, 1, 1, 4'd0, 1, 1, 0, 0);
        add(0, OP_BR, 3'b010, 1, 1, 1, 1, 4'd1, 0, 0, 0, 0);
        add(0, OP_BR, 3'b010, 1, 1, 1, 1, 4'd9, 0, 0, 0, 0);
        add(1, OP_BR, 3'b010, 1, 1, 1, 0, 4'd0, 0, 0, 0, 1);
        add(0, OP_BR, 3'b011, 1, 1, 1, 1, 4'd0, 1, 1, 0, 0);
        add(0, OP_BR, 3'b011, 1, 1, 1, 1, 4'd1, 0, 0, 0, 0);
        add(0, OP_BR, 3'b011, 1, 1, 1, 1, 4'd9, 0, 0, 0, 0);
        add(0, OP_BR, 3'b011, 1, 1, 1, 0, 4'd0, 0, 0, 0, 1);

        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
